// File: rtl/branch_predictor_pkg.sv
// Shared types for the branch predictor: word width and 2-bit counter encodings.
package branch_predictor_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

endpackage

// File: rtl/branch_predictor_ctr_next.sv
// Saturating next-state function for a 2-bit branch counter.
module bp_ctr_next
    import branch_predictor_pkg::*;
(
    input  ctr_e ctr_i,
    input  logic taken_i,
    output ctr_e ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        if (taken_i) begin
            case (ctr_i)
                CTR_SNT: ctr_o = CTR_WNT;
                CTR_WNT: ctr_o = CTR_WT;
                default: ctr_o = CTR_ST;
            endcase
        end else begin
            case (ctr_i)
                CTR_ST:  ctr_o = CTR_WT;
                CTR_WT:  ctr_o = CTR_WNT;
                default: ctr_o = CTR_SNT;
            endcase
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit-counter branch predictor with tag/target table.
// Optional statistics counters are enabled with `define BP_STATS_EN.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned INDEX_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] if_pc,
    output logic              pred_taken,
    output logic [WORD_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [WORD_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [WORD_W-1:0] upd_target,
    input  logic              upd_pred_taken,
    input  logic [WORD_W-1:0] upd_pred_target,
    output logic              mispredict
`ifdef BP_STATS_EN
    ,
    output logic [WORD_W-1:0] stat_branches,
    output logic [WORD_W-1:0] stat_mispredicts
`endif
);

    localparam int unsigned TAG_W = WORD_W - INDEX_W - 2;

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [WORD_W-1:0] target_q [ENTRIES];
    ctr_e              ctr_q    [ENTRIES];

    logic [INDEX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0]   lk_tag, up_tag;
    logic               lk_hit, up_hit;
    ctr_e               lk_ctr;
    ctr_e               up_ctr_d;
    logic               unused_pc_bits;

    assign unused_pc_bits = ^{if_pc[1:0], upd_pc[1:0]};

    assign lk_idx = if_pc[INDEX_W+1:2];
    assign lk_tag = if_pc[WORD_W-1:INDEX_W+2];
    assign up_idx = upd_pc[INDEX_W+1:2];
    assign up_tag = upd_pc[WORD_W-1:INDEX_W+2];

    // Lookup reads registered state only; a same-cycle update is not bypassed.
    assign lk_ctr      = ctr_q[lk_idx];
    assign lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign pred_taken  = lk_hit && lk_ctr[1];
    assign pred_target = pred_taken ? target_q[lk_idx] : '0;

    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    bp_ctr_next u_ctr_next (
        .ctr_i   (ctr_q[up_idx]),
        .taken_i (upd_taken),
        .ctr_o   (up_ctr_d)
    );

    // Gated by rst_n so the flush request drops as soon as reset asserts.
    assign mispredict = rst_n && upd_valid &&
                        ((upd_pred_taken != upd_taken) ||
                         (upd_taken && (upd_pred_target != upd_target)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WNT;
            end
        end else if (upd_valid) begin
            if (up_hit) begin
                ctr_q[up_idx] <= up_ctr_d;
                if (upd_taken) begin
                    target_q[up_idx] <= upd_target;
                end
            end else if (upd_taken) begin
                valid_q[up_idx]  <= 1'b1;
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= upd_target;
                ctr_q[up_idx]    <= CTR_WT;
            end
        end
    end

`ifdef BP_STATS_EN
    logic [WORD_W-1:0] stat_branches_q, stat_branches_d;
    logic [WORD_W-1:0] stat_mispredicts_q, stat_mispredicts_d;

    always_comb begin
        stat_branches_d    = stat_branches_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (upd_valid && (stat_branches_q != '1)) begin
            stat_branches_d = stat_branches_q + 1'b1;
        end
        if (mispredict && (stat_mispredicts_q != '1)) begin
            stat_mispredicts_d = stat_mispredicts_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            stat_branches_q    <= stat_branches_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: spec-level table model plus scoreboard queues.
`timescale 1ns/1ps
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        mispredict;
`ifdef BP_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    always #5 clk = ~clk;

    branch_predictor #(.ENTRIES(64), .INDEX_W(6)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .if_pc           (if_pc),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .mispredict      (mispredict)
`ifdef BP_STATS_EN
        ,
        .stat_branches   (stat_branches),
        .stat_mispredicts(stat_mispredicts)
`endif
    );

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
        logic        misp;
    } exp_t;

    exp_t exp_q[$];
    exp_t obs_q[$];
    exp_t last;
    int   n_tests = 0;
    int   n_fail  = 0;

    localparam logic [31:0] PC_A = 32'h0040_0010;
    localparam logic [31:0] PC_B = 32'h0040_0110;
    localparam logic [31:0] PC_C = 32'h0040_0020;
    localparam logic [31:0] PC_D = 32'h0040_0024;

    // Reference table, written straight from the operational description.
    logic        m_valid [64];
    logic [23:0] m_tag   [64];
    logic [31:0] m_tgt   [64];
    logic [1:0]  m_ctr   [64];
    int          m_branches;
    int          m_misp;

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 2'b01;
        end
        m_branches = 0;
        m_misp     = 0;
    endfunction

    task automatic model_pred(input logic [31:0] pc, output logic t, output logic [31:0] tg);
        int  i;
        logic h;
        logic [1:0] c;
        i  = int'(pc[7:2]);
        h  = m_valid[i] && (m_tag[i] == pc[31:8]);
        c  = m_ctr[i];
        t  = h && c[1];
        tg = t ? m_tgt[i] : 32'h0;
    endtask

    task automatic model_update(input logic [31:0] pc, input logic t, input logic [31:0] tg);
        int i;
        i = int'(pc[7:2]);
        if (m_valid[i] && (m_tag[i] == pc[31:8])) begin
            if (t) begin
                if (m_ctr[i] != 2'b11) m_ctr[i] = m_ctr[i] + 2'b01;
                m_tgt[i] = tg;
            end else begin
                if (m_ctr[i] != 2'b00) m_ctr[i] = m_ctr[i] - 2'b01;
            end
        end else if (t) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = pc[31:8];
            m_tgt[i]   = tg;
            m_ctr[i]   = 2'b10;
        end
    endtask

    // One pipeline cycle, entered and left at a falling edge.
    task automatic step(input logic [31:0] pc, input logic uv, input logic [31:0] upc,
                        input logic ut, input logic [31:0] utgt,
                        input logic upt, input logic [31:0] uptgt);
        exp_t e;
        exp_t o;
        if_pc = pc; upd_valid = uv; upd_pc = upc; upd_taken = ut;
        upd_target = utgt; upd_pred_taken = upt; upd_pred_target = uptgt;
        #1;
        model_pred(pc, e.taken, e.target);
        e.misp   = uv && ((upt != ut) || (ut && (uptgt != utgt)));
        o.taken  = pred_taken;
        o.target = pred_target;
        o.misp   = mispredict;
        exp_q.push_back(e);
        obs_q.push_back(o);
        last = o;
        @(posedge clk);
        if (uv) begin
            model_update(upc, ut, utgt);
            m_branches++;
            if (e.misp) m_misp++;
        end
        @(negedge clk);
        upd_valid = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] pc);
        step(pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic test_reset();
        exp_t e, o;
        rst_n = 1'b0;
        if_pc = PC_A; upd_valid = 1'b1; upd_pc = PC_A; upd_taken = 1'b1;
        upd_target = 32'h1234_5678; upd_pred_taken = 1'b0; upd_pred_target = 32'h0;
        #1;
        n_tests++;
        if (mispredict !== 1'b0) begin n_fail++; $display("FAIL reset_misp: got %b want 0", mispredict); end
        n_tests++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h0) begin
            n_fail++; $display("FAIL reset_pred: got %b/%h want 0/00000000", pred_taken, pred_target);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        upd_valid = 1'b0;
        rst_n = 1'b1;
        model_reset();
        lookup(PC_A);
        n_tests++;
        if (last.taken !== 1'b0 || last.target !== 32'h0 || last.misp !== 1'b0) begin
            n_fail++; $display("FAIL reset_lookup: got %b/%h/%b want 0/00000000/0", last.taken, last.target, last.misp);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL reset_sb: got %b/%h/%b want %b/%h/%b", o.taken, o.target, o.misp, e.taken, e.target, e.misp); end
        end
    endtask

    task automatic test_allocate();
        exp_t e, o;
        step(PC_A, 1'b1, PC_A, 1'b1, 32'h0040_0100, 1'b0, 32'h0);
        n_tests++;
        if (last.misp !== 1'b1) begin n_fail++; $display("FAIL alloc_misp: got %b want 1", last.misp); end
        lookup(PC_A);
        n_tests++;
        if (last.taken !== 1'b1 || last.target !== 32'h0040_0100) begin
            n_fail++; $display("FAIL alloc_pred: got %b/%h want 1/00400100", last.taken, last.target);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL alloc_sb: got %b/%h/%b want %b/%h/%b", o.taken, o.target, o.misp, e.taken, e.target, e.misp); end
        end
    endtask

    task automatic test_saturation();
        exp_t e, o;
        logic        pt;
        logic [31:0] ptg;
        // WT -> ST after one taken; two more taken must hold ST.
        repeat (3) begin
            model_pred(PC_A, pt, ptg);
            step(PC_A, 1'b1, PC_A, 1'b1, 32'h0040_0100, pt, ptg);
        end
        repeat (2) begin
            model_pred(PC_A, pt, ptg);
            step(PC_A, 1'b1, PC_A, 1'b0, 32'h0, pt, ptg);
        end
        lookup(PC_A);
        n_tests++;
        if (last.taken !== 1'b0) begin n_fail++; $display("FAIL sat_wnt_pred: got %b want 0", last.taken); end
        repeat (3) step(PC_A, 1'b1, PC_A, 1'b0, 32'h0, 1'b0, 32'h0);
        // From SNT one taken gives WNT (still not taken); a second gives WT.
        step(PC_A, 1'b1, PC_A, 1'b1, 32'h0040_0100, 1'b0, 32'h0);
        lookup(PC_A);
        n_tests++;
        if (last.taken !== 1'b0) begin n_fail++; $display("FAIL sat_snt_hold: got %b want 0", last.taken); end
        step(PC_A, 1'b1, PC_A, 1'b1, 32'h0040_0100, 1'b0, 32'h0);
        lookup(PC_A);
        n_tests++;
        if (last.taken !== 1'b1 || last.target !== 32'h0040_0100) begin
            n_fail++; $display("FAIL sat_wt_pred: got %b/%h want 1/00400100", last.taken, last.target);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL sat_sb: got %b/%h/%b want %b/%h/%b", o.taken, o.target, o.misp, e.taken, e.target, e.misp); end
        end
    endtask

    task automatic test_alias();
        exp_t e, o;
        step(PC_A, 1'b1, PC_B, 1'b1, 32'h0040_0200, 1'b0, 32'h0);
        lookup(PC_A);
        n_tests++;
        if (last.taken !== 1'b0 || last.target !== 32'h0) begin
            n_fail++; $display("FAIL alias_evict: got %b/%h want 0/00000000", last.taken, last.target);
        end
        // Not-taken miss at the same index must leave PC_B intact; low PC bits are ignored.
        step(PC_B | 32'h3, 1'b1, 32'h0040_0212, 1'b0, 32'h0, 1'b0, 32'h0);
        lookup(PC_B | 32'h3);
        n_tests++;
        if (last.taken !== 1'b1 || last.target !== 32'h0040_0200) begin
            n_fail++; $display("FAIL alias_pred: got %b/%h want 1/00400200", last.taken, last.target);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL alias_sb: got %b/%h/%b want %b/%h/%b", o.taken, o.target, o.misp, e.taken, e.target, e.misp); end
        end
    endtask

    task automatic test_target_mismatch();
        exp_t e, o;
        step(PC_A, 1'b1, PC_A, 1'b1, 32'h0040_0100, 1'b0, 32'h0);
        step(PC_A, 1'b1, PC_A, 1'b1, 32'h0040_0180, 1'b1, 32'h0040_0100);
        n_tests++;
        if (last.misp !== 1'b1) begin n_fail++; $display("FAIL tgt_misp: got %b want 1", last.misp); end
        lookup(PC_A);
        n_tests++;
        if (last.taken !== 1'b1 || last.target !== 32'h0040_0180) begin
            n_fail++; $display("FAIL tgt_pred: got %b/%h want 1/00400180", last.taken, last.target);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL tgt_sb: got %b/%h/%b want %b/%h/%b", o.taken, o.target, o.misp, e.taken, e.target, e.misp); end
        end
    endtask

    task automatic test_same_cycle_and_idle();
        exp_t e, o;
        step(PC_A, 1'b1, PC_A, 1'b1, 32'h0040_0300, 1'b1, 32'h0040_0180);
        n_tests++;
        if (last.target !== 32'h0040_0180) begin n_fail++; $display("FAIL nobypass: got %h want 00400180", last.target); end
        // upd_valid low with inconsistent carried values: no flush, no training.
        step(PC_A, 1'b0, PC_A, 1'b0, 32'h0, 1'b1, 32'hdead_beef);
        n_tests++;
        if (last.misp !== 1'b0 || last.target !== 32'h0040_0300) begin
            n_fail++; $display("FAIL idle: got misp=%b tgt=%h want 0/00400300", last.misp, last.target);
        end
        lookup(PC_A);
        n_tests++;
        if (last.target !== 32'h0040_0300) begin n_fail++; $display("FAIL idle_hold: got %h want 00400300", last.target); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL same_sb: got %b/%h/%b want %b/%h/%b", o.taken, o.target, o.misp, e.taken, e.target, e.misp); end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e, o;
        logic [31:0] lpc, upc, utgt, ptg;
        logic        ut, pt;
        for (int n = 0; n < 60; n++) begin
            lpc  = 32'h0040_0000 | (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            upc  = 32'h0040_0000 | (32'($urandom_range(0, 2)) << 8) | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            ut   = 1'($urandom_range(0, 1));
            utgt = 32'h0050_0000 | (32'($urandom_range(0, 3)) << 4);
            model_pred(upc, pt, ptg);
            if ($urandom_range(0, 4) == 0) pt = ~pt;
            step(lpc, 1'($urandom_range(0, 5) != 0), upc, ut, utgt, pt, ptg);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL b2b_sb: got %b/%h/%b want %b/%h/%b", o.taken, o.target, o.misp, e.taken, e.target, e.misp); end
        end
    endtask

    task automatic test_stats_and_reset();
        exp_t e, o;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(PC_C, 1'b1, PC_C, 1'b1, 32'h0040_0400, 1'b0, 32'h0);
        step(PC_C, 1'b1, PC_C, 1'b1, 32'h0040_0400, 1'b1, 32'h0040_0400);
        step(PC_C, 1'b1, PC_D, 1'b0, 32'h0, 1'b0, 32'h0);
        step(PC_C, 1'b1, PC_C, 1'b1, 32'h0040_0400, 1'b1, 32'h0040_0400);
        step(PC_C, 1'b1, PC_C, 1'b1, 32'h0040_0480, 1'b1, 32'h0040_0400);
`ifdef BP_STATS_EN
        n_tests++;
        if (stat_branches !== 32'd5 || stat_mispredicts !== 32'd2) begin
            n_fail++; $display("FAIL stats_count: got %0d/%0d want 5/2", stat_branches, stat_mispredicts);
        end
        n_tests++;
        if (stat_branches !== 32'(m_branches) || stat_mispredicts !== 32'(m_misp)) begin
            n_fail++; $display("FAIL stats_model: got %0d/%0d want %0d/%0d", stat_branches, stat_mispredicts, m_branches, m_misp);
        end
`endif
        // Reset asserted between edges while an update is pending.
        if_pc = PC_C; upd_valid = 1'b1; upd_pc = PC_C; upd_taken = 1'b1;
        upd_target = 32'h0040_0444; upd_pred_taken = 1'b0; upd_pred_target = 32'h0;
        #1;
        n_tests++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h0040_0480) begin
            n_fail++; $display("FAIL prereset_pred: got %b/%h want 1/00400480", pred_taken, pred_target);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h0 || mispredict !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: got %b/%h/%b want 0/00000000/0", pred_taken, pred_target, mispredict);
        end
`ifdef BP_STATS_EN
        n_tests++;
        if (stat_branches !== 32'd0 || stat_mispredicts !== 32'd0) begin
            n_fail++; $display("FAIL async_stats: got %0d/%0d want 0/0", stat_branches, stat_mispredicts);
        end
`endif
        @(posedge clk);
        @(negedge clk);
        upd_valid = 1'b0;
        rst_n = 1'b1;
        model_reset();
        lookup(PC_C);
        n_tests++;
        if (last.taken !== 1'b0) begin n_fail++; $display("FAIL reset_discard: got %b want 0", last.taken); end
`ifdef BP_STATS_EN
        n_tests++;
        if (stat_branches !== 32'd0) begin n_fail++; $display("FAIL stats_after: got %0d want 0", stat_branches); end
`endif
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL stats_sb: got %b/%h/%b want %b/%h/%b", o.taken, o.target, o.misp, e.taken, e.target, e.misp); end
        end
    endtask

    initial begin
        test_reset();
        test_allocate();
        test_saturation();
        test_alias();
        test_target_mismatch();
        test_same_cycle_and_idle();
        test_back_to_back();
        test_stats_and_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the five-stage pipeline. In IF it looks up the fetch PC in a direct-mapped table of 2-bit saturating counters with tags and targets, and drives a taken/target prediction to the next-PC mux. In ID it takes the resolved outcome from the branch comparator and decoder. It trains the table and flags a mispredict so the pipeline can flush and redirect.

## Interface
- ENTRIES, 64: number of table entries; power of two.
- INDEX_W, 6: log2(ENTRIES); index is pc[INDEX_W+1:2], tag is pc[31:INDEX_W+2].
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- if_pc  in  32  fetch PC to look up.
- pred_taken  out  1  prediction for if_pc, combinational from current table state.
- pred_target  out  32  predicted target for if_pc; 0 when pred_taken=0.
- upd_valid  in  1  ID stage holds a resolved conditional branch this cycle.
- upd_pc  in  32  PC of the resolved branch.
- upd_taken  in  1  actual outcome from branch resolution.
- upd_target  in  32  actual branch target computed in ID.
- upd_pred_taken  in  1  pred_taken carried down the pipe with this branch.
- upd_pred_target  in  32  pred_target carried down the pipe with this branch.
- mispredict  out  1  combinational; prediction for the resolving branch was wrong.
- stat_branches  out  32  present only with BP_STATS_EN.
- stat_mispredicts  out  32  present only with BP_STATS_EN.

## Operation
- Per entry:
  - valid (1b)
  - tag (32-INDEX_W-2 b)
  - target (32b)
  - ctr (2b): SNT=00, WNT=01, WT=10, ST=11.
- Lookup hits when valid && tag match. pred_taken = hit && ctr[1]. pred_target = upd target field when pred_taken, else 0.
- Update, only when upd_valid=1, written at the clock edge:
  - Hit, taken: ctr increments, saturating at ST; target ← upd_target.
  - Hit, not taken: ctr decrements, saturating at SNT; target unchanged.
  - Miss, taken: allocate and overwrite any previous occupant. valid←1, tag←upd_pc tag, target←upd_target, ctr←WT.
  - Miss, not taken: no state change.
- mispredict = upd_valid && ((upd_pred_taken != upd_taken) || (upd_taken && upd_pred_target != upd_target)).
- mispredict is 0 whenever upd_valid=0, regardless of the other upd_* inputs.
- upd_pc[1:0] and if_pc[1:0] are ignored.

## Timing
- Lookup has zero latency, combinational from registered state.
- Update becomes visible to lookup on the cycle after the edge.
- Same-index lookup and update in one cycle: lookup returns the pre-update value; there is no bypass.
- Stalls are handled by the pipeline, which must hold upd_valid=0 for a stalled or flushed ID slot. The block has no stall input.
- Reset, asynchronous on rst_n low, takes effect immediately, including mid-update:
  - every valid←0, every ctr←WNT, tags and targets←0
  - pred_taken=0, pred_target=0, mispredict=0
  - stat counters←0
- An update pending in the cycle reset asserts is discarded.

## Configuration
- BP_STATS_EN defined:
  - stat_branches increments on every upd_valid.
  - stat_mispredicts increments on every mispredict.
  - Both are 32-bit, saturate at 0xFFFFFFFF, and are registered (visible the cycle after the event).
- BP_STATS_EN undefined: both ports and both counters are absent. Prediction behaviour is identical.

## Structure
- Shared header defines.vh holds the counter encodings, BP_CTR_SNT/WNT/WT/ST. Reuse its existing word-width macro for PC and target widths.
- Sub-module bp_ctr_next is natural: a pure function mapping (ctr, taken) to the saturating next ctr, instantiated once on the update path.
- Table storage is flop arrays in branch_predictor itself, so that reset can clear the valid bits.

## Test plan
- After reset, if_pc=0x00400010: pred_taken=0, pred_target=0, mispredict=0.
- Taken miss allocates. Update upd_pc=0x00400010, taken, target 0x00400100, upd_pred_taken=0: mispredict=1 that cycle. Next cycle, lookup 0x00400010 gives pred_taken=1, target 0x00400100.
- Saturation, same PC:
  - Three taken updates reach ST.
  - Two not-taken updates give WNT, and pred_taken=0.
  - A third not-taken update reaches SNT, and further not-taken updates stay at SNT.
- Aliasing. After the allocation above, update 0x00400110 (same index, different tag) taken to 0x00400200. Lookup 0x00400010 then misses (pred_taken=0), and 0x00400110 predicts 0x00400200.
- Target mismatch. Predicted taken to 0x00400100, actual taken to 0x00400180: mispredict=1, and the next lookup returns 0x00400180.
- With BP_STATS_EN, run 5 updates with 2 mispredicts: stat_branches=5, stat_mispredicts=2. Asserting rst_n low mid-sequence zeroes both counters asynchronously.
